// File: rtl/ram_bridge_pkg.sv
// Shared types and helpers for the AXI4-Lite to data-RAM bridge.
package ram_bridge_pkg;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ACCESS,
      R_RESP
   } r_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ACCESS,
      W_RESP
   } w_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // True when addr falls inside [base, base+bytes); subtracting avoids
   // overflow when the window ends at the top of the address space.
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] bytes);
      return (addr >= base) && ((addr - base) < bytes);
   endfunction

endpackage

// File: rtl/strb_to_mask.sv
// Byte-strobe to bit-mask expander (pure combinational).
module strb_to_mask #(
   parameter int unsigned STRB_W = 8
) (
   input  logic [STRB_W-1:0]   strb,
   output logic [STRB_W*8-1:0] mask
);

   // Replicate each strobe bit across its byte lane
   always_comb begin
      mask = '0;
      for (int unsigned k = 0; k < STRB_W; k++) begin
         mask[k*8 +: 8] = {8{strb[k]}};
      end
   end

endmodule

// File: rtl/axi_lite_ram_bridge.sv
// AXI4-Lite slave driving the data RAM's single-cycle read/write strobes.
// Optional address range check: define RAM_BRIDGE_RANGE_CHECK_EN to answer
// out-of-window accesses with SLVERR and no RAM access.
module axi_lite_ram_bridge
   import ram_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 64,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] MEM_BYTES = 32'd32768
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic                bvalid,
   input  logic                bready,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ADDR_W-1:0]   araddr,
   output logic                rvalid,
   input  logic                rready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic [ADDR_W-1:0]   ram_waddr_o,
   output logic [DATA_W-1:0]   ram_wdata_o,
   output logic [DATA_W-1:0]   ram_wmask_o,
   output logic                ram_wen_o,
   output logic [ADDR_W-1:0]   ram_raddr_o,
   output logic                ram_ren_o,
   input  logic [DATA_W-1:0]   ram_rdata_i
);

   localparam int unsigned STRB_W = DATA_W / 8;

`ifdef RAM_BRIDGE_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif

   r_state_t            r_state, r_next;
   w_state_t            w_state, w_next;
   logic                alive;
   logic [ADDR_W-1:3]   raddr_q, waddr_q;
   logic [DATA_W-1:0]   rdata_q, wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic                aw_got, w_got;
   logic [1:0]          rresp_q, bresp_q;
   logic                ar_hs, aw_hs, w_hs, w_both, b_hs;
   logic                rd_err, wr_err, collide;
   logic [ADDR_W-1:0]   wr_chk_addr;
   logic [DATA_W-1:0]   mask;

   // Handshake outputs and strobes decoded from registered state only
   assign arready   = alive && (r_state == R_IDLE);
   assign awready   = alive && (w_state == W_IDLE) && !aw_got;
   assign wready    = alive && (w_state == W_IDLE) && !w_got;
   assign rvalid    = (r_state == R_RESP);
   assign bvalid    = (w_state == W_RESP);
   assign ram_ren_o = (r_state == R_ACCESS);
   assign ram_wen_o = (w_state == W_ACCESS);

   assign ar_hs  = arvalid && arready;
   assign aw_hs  = awvalid && awready;
   assign w_hs   = wvalid && wready;
   assign b_hs   = bvalid && bready;
   assign w_both = (aw_got || aw_hs) && (w_got || w_hs);

   // The write address may arrive in the completing cycle or earlier
   assign wr_chk_addr = aw_hs ? awaddr : {waddr_q, 3'b000};
   assign rd_err = RANGE_CHECK && !in_range(araddr, BASE_ADDR, MEM_BYTES);
   assign wr_err = RANGE_CHECK && !in_range(wr_chk_addr, BASE_ADDR, MEM_BYTES);

   // Same-word read during the write strobe would see stale data
   assign collide = (r_state == R_ACCESS) && (w_state == W_ACCESS) &&
                    (raddr_q == waddr_q);

   strb_to_mask #(.STRB_W(STRB_W)) u_mask (
      .strb (wstrb_q),
      .mask (mask)
   );

   assign ram_raddr_o = {raddr_q, 3'b000};
   assign ram_waddr_o = {waddr_q, 3'b000};
   assign ram_wmask_o = mask;
   assign ram_wdata_o = wdata_q & mask;
   assign rdata       = rdata_q;
   assign rresp       = rresp_q;
   assign bresp       = bresp_q;

   // State registers; alive holds readies low until the first edge out of reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
         alive   <= 1'b0;
      end else begin
         r_state <= r_next;
         w_state <= w_next;
         alive   <= 1'b1;
      end
   end

   // Read next-state: errored reads skip the RAM access
   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:   if (ar_hs) r_next = rd_err ? R_RESP : R_ACCESS;
         R_ACCESS: if (!collide) r_next = R_RESP;
         R_RESP:   if (rready) r_next = R_IDLE;
         default:  r_next = R_IDLE;
      endcase
   end

   // Write next-state: leave idle once both address and data are held
   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:   if (w_both) w_next = wr_err ? W_RESP : W_ACCESS;
         W_ACCESS: w_next = W_RESP;
         W_RESP:   if (bready) w_next = W_IDLE;
         default:  w_next = W_IDLE;
      endcase
   end

   // Read datapath: latch address at AR, capture RAM data at end of access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         raddr_q <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         if (ar_hs) begin
            raddr_q <= araddr[ADDR_W-1:3];
            rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            if (rd_err) rdata_q <= '0;
         end
         if (ram_ren_o && !collide) rdata_q <= ram_rdata_i;
      end
   end

   // Write datapath: independent AW/W capture flags, cleared on B handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         waddr_q <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         bresp_q <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            waddr_q <= awaddr[ADDR_W-1:3];
            aw_got  <= 1'b1;
         end
         if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            w_got   <= 1'b1;
         end
         if ((w_state == W_IDLE) && w_both) begin
            bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end
         if (b_hs) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// Self-checking bench for axi_lite_ram_bridge with a byte-level memory model.
// Honours RAM_BRIDGE_RANGE_CHECK_EN when deciding expected responses.
module tb_axi_lite_ram_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, araddr, ram_waddr_o, ram_raddr_o;
   logic [63:0] wdata, rdata, ram_wdata_o, ram_wmask_o, ram_rdata_i;
   logic [7:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        ram_wen_o, ram_ren_o;

   logic [63:0] mem [0:4095] = '{default: '0};
   logic [7:0]  ref_bytes [0:32767] = '{default: '0};

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int wen_cnt = 0;
   int ren_cnt = 0;
   int wen_cyc = 0;
   logic [31:0] cap_waddr;
   logic [63:0] cap_wdata, cap_wmask;

   always #5 clk = ~clk;

   axi_lite_ram_bridge dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
      .ram_wmask_o(ram_wmask_o), .ram_wen_o(ram_wen_o),
      .ram_raddr_o(ram_raddr_o), .ram_ren_o(ram_ren_o),
      .ram_rdata_i(ram_rdata_i)
   );

   // RAM: combinational read, masked OR-merge write at the clock edge
   assign ram_rdata_i = mem[ram_raddr_o[14:3]];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_wen_o)
         mem[ram_waddr_o[14:3]] <= (mem[ram_waddr_o[14:3]] & ~ram_wmask_o) | ram_wdata_o;
   end

   // Strobe monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (ram_wen_o) begin
         wen_cnt   <= wen_cnt + 1;
         wen_cyc   <= cyc;
         cap_waddr <= ram_waddr_o;
         cap_wdata <= ram_wdata_o;
         cap_wmask <= ram_wmask_o;
      end
      if (ram_ren_o) ren_cnt <= ren_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit exp_err(input logic [31:0] a);
`ifdef RAM_BRIDGE_RANGE_CHECK_EN
      return !((a >= 32'h8000_0000) && (a < 32'h8000_8000));
`else
      return (a == 32'h0) && 1'b0;
`endif
   endfunction

   function automatic logic [63:0] mask_of(input logic [7:0] s);
      logic [63:0] m;
      m = '0;
      for (int k = 0; k < 8; k++) if (s[k]) m[k*8 +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic [63:0] ref_read(input logic [31:0] a);
      logic [63:0] r;
      int b;
      b = int'(a[14:3]) * 8;
      for (int k = 0; k < 8; k++) r[k*8 +: 8] = ref_bytes[b + k];
      return r;
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      int b;
      b = int'(a[14:3]) * 8;
      for (int k = 0; k < 8; k++) if (s[k]) ref_bytes[b + k] = d[k*8 +: 8];
   endtask

   // lead > 0: W presented lead cycles before AW; lead < 0: AW first
   task automatic do_write(input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] s, input int lead);
      int t, aw_e, w_e, last_e, wen0, hold;
      bit aw_d, w_d, err;
      err = exp_err(a); wen0 = wen_cnt;
      aw_d = 0; w_d = 0; t = 0; aw_e = 0; w_e = 0;
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_d && w_d) && t < 50) begin
         @(negedge clk);
         awvalid = !aw_d && (t >= lead);
         wvalid  = !w_d && (t >= -lead);
         if (w_d && !aw_d) check("wready_low", 64'(wready), 64'd0);
         if (aw_d && !w_d) check("awready_low", 64'(awready), 64'd0);
         if (awvalid && awready) begin aw_d = 1; aw_e = cyc + 1; end
         if (wvalid && wready) begin w_d = 1; w_e = cyc + 1; end
         t++;
      end
      check("aw_w_accept", 64'({aw_d, w_d}), 64'd3);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      last_e = (aw_e > w_e) ? aw_e : w_e;
      t = 0;
      while (!bvalid && t < 20) begin @(negedge clk); t++; end
      check("bvalid_seen", 64'(bvalid), 64'd1);
      check("b_latency", 64'(cyc - last_e), 64'(err ? 0 : 1));
      check("bresp", 64'(bresp), 64'(err ? 2 : 0));
      check("wen_pulses", 64'(wen_cnt - wen0), 64'(err ? 0 : 1));
      if (!err) begin
         check("wen_cycle", 64'(wen_cyc), 64'(last_e));
         check("ram_waddr", 64'(cap_waddr), 64'({a[31:3], 3'b000}));
         check("ram_wmask", cap_wmask, mask_of(s));
         check("ram_wdata", cap_wdata, d & mask_of(s));
         ref_write(a, d, s);
      end
      hold = $urandom_range(0, 2);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("bvalid_hold", 64'(bvalid), 64'd1);
      end
      bready = 1;
      @(negedge clk);
      bready = 0;
      check("bvalid_drop", 64'(bvalid), 64'd0);
      check("awready_back", 64'(awready), 64'd1);
   endtask

   task automatic do_read(input logic [31:0] a, input int stall, input bit coll,
                          input bit use_ov, input logic [63:0] ov);
      int t, ar_e, ren0;
      bit got, err;
      logic [63:0] exp;
      err = exp_err(a); ren0 = ren_cnt; araddr = a; t = 0; ar_e = 0; got = 0;
      while (!got && t < 50) begin
         @(negedge clk);
         arvalid = 1;
         if (arready) begin got = 1; ar_e = cyc + 1; end
         t++;
      end
      check("ar_accept", 64'(got), 64'd1);
      @(negedge clk);
      arvalid = 0;
      exp = use_ov ? ov : (err ? 64'd0 : ref_read(a));
      t = 0;
      while (!rvalid && t < 20) begin @(negedge clk); t++; end
      check("rvalid_seen", 64'(rvalid), 64'd1);
      check("r_latency", 64'(cyc - ar_e), 64'(err ? 0 : (coll ? 2 : 1)));
      check("ren_pulses", 64'(ren_cnt - ren0), 64'(err ? 0 : (coll ? 2 : 1)));
      check("rdata", rdata, exp);
      check("rresp", 64'(rresp), 64'(err ? 2 : 0));
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check("rvalid_hold", 64'(rvalid), 64'd1);
         check("rdata_hold", rdata, exp);
         check("arready_busy", 64'(arready), 64'd0);
      end
      rready = 1;
      @(negedge clk);
      rready = 0;
      check("rvalid_drop", 64'(rvalid), 64'd0);
      check("arready_back", 64'(arready), 64'd1);
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return $urandom();
      return 32'h8000_0000 + ($urandom_range(0, 15) << 3) + $urandom_range(0, 7);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] newv;
      int t;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      repeat (2) @(negedge clk);

      check("rst_arready", 64'(arready), 64'd0);
      check("rst_awready", 64'(awready), 64'd0);
      check("rst_wready", 64'(wready), 64'd0);
      check("rst_valids", 64'({rvalid, bvalid}), 64'd0);
      check("rst_strobes", 64'({ram_ren_o, ram_wen_o}), 64'd0);
      check("rst_waddr", 64'(ram_waddr_o), 64'd0);
      check("rst_raddr", 64'(ram_raddr_o), 64'd0);
      check("rst_wdata", ram_wdata_o, 64'd0);
      check("rst_wmask", ram_wmask_o, 64'd0);
      check("rst_rdata", rdata, 64'd0);
      check("rst_resp", 64'({rresp, bresp}), 64'd0);

      rst = 1;
      check("ready_before_edge", 64'({arready, awready, wready}), 64'd0);
      @(negedge clk);
      check("ready_after_edge", 64'({arready, awready, wready}), 64'd7);

      do_write(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0);
      do_read(32'h8000_0010, 0, 0, 0, '0);
      do_write(32'h8000_0014, 64'hAABB_CCDD_EEFF_0011, 8'h0F, 0);
      do_read(32'h8000_0010, 0, 0, 1, 64'h1122_3344_EEFF_0011);
      do_write(32'h8000_0020, {$urandom(), $urandom()}, 8'hA5, 3);
      do_write(32'h8000_0028, {$urandom(), $urandom()}, 8'h3C, -2);

      // Read and write to the same word handshaking on the same edge
      newv = (ref_read(32'h8000_0010) & ~mask_of(8'hF0)) |
             (64'hDEAD_BEEF_0BAD_F00D & mask_of(8'hF0));
      fork
         do_write(32'h8000_0010, 64'hDEAD_BEEF_0BAD_F00D, 8'hF0, 0);
         do_read(32'h8000_0010, 0, 1, 1, newv);
      join

      do_read(32'h8000_0010, 5, 0, 0, '0);
      do_read(32'h7FFF_FFF8, 0, 0, 0, '0);
      do_write(32'h8000_8000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
      do_read(32'h8000_0000, 0, 0, 0, '0);

      // Reset pulsed while a read response is pending
      araddr = 32'h8000_0020;
      @(negedge clk); arvalid = 1;
      @(negedge clk); arvalid = 0;
      t = 0;
      while (!rvalid && t < 20) begin @(negedge clk); t++; end
      check("pre_rst_rvalid", 64'(rvalid), 64'd1);
      rst = 0;
      #1;
      check("rst_mid_rvalid", 64'(rvalid), 64'd0);
      check("rst_mid_arready", 64'(arready), 64'd0);
      check("rst_mid_strobes", 64'({ram_ren_o, ram_wen_o}), 64'd0);
      @(negedge clk);
      rst = 1;
      check("release_arready_low", 64'(arready), 64'd0);
      @(negedge clk);
      check("release_arready_high", 64'(arready), 64'd1);
      check("release_rvalid", 64'(rvalid), 64'd0);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 1) == 0)
            do_write(rand_addr(), {$urandom(), $urandom()}, 8'($urandom()),
                     $urandom_range(0, 6) - 3);
         else
            do_read(rand_addr(), $urandom_range(0, 3), 0, 0, '0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
